// File: rtl/sram_vec_reader.sv
// Streams a run of consecutive SRAM words through an Avalon-MM read master into a
// small FIFO, and presents them in order on a valid/ready output.
module sram_vec_reader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [BE_WIDTH-1:0]   m_byteenable,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_WIDTH-1:0] m_writedata,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    input  logic                  m_waitrequest,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_LEFT = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic                    zero_done_q;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_count;

    logic                    job_load;
    logic                    zero_job;
    logic                    accept;
    logic                    pop;

    assign m_write      = 1'b0;
    assign m_writedata  = '0;
    assign m_byteenable = '1;
    assign m_address    = addr_q;

    // m_read depends on registered state only, so no path from waitrequest/out_ready.
    assign m_read    = (state_q == READ) && (fifo_count != FULL_CNT);
    assign accept    = m_read && !m_waitrequest;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = (state_q != IDLE);

    assign job_load = (state_q == IDLE) && start && (word_count != '0);
    assign zero_job = (state_q == IDLE) && start && (word_count == '0);

    // abort suppresses a completion pulse that would otherwise land in its cycle.
    assign done = !abort && (zero_done_q || ((state_q == DRAIN) && (fifo_count == '0)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_load) state_d = READ;
            READ:    if (accept && (remaining_q == ONE_LEFT)) state_d = DRAIN;
            DRAIN:   if (fifo_count == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            zero_done_q <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            state_q     <= state_d;
            zero_done_q <= zero_job && !abort;
            if (abort) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (job_load) begin
                    addr_q      <= base_addr;
                    remaining_q <= word_count;
                end else if (accept) begin
                    addr_q      <= addr_q + ADDR_WIDTH'(1);
                    remaining_q <= remaining_q - ONE_LEFT;
                end
                if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({accept, pop})
                    2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                    2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept && !abort) mem[wr_ptr] <= m_readdata;
    end

endmodule

// File: tb/tb_sram_vec_reader.sv
// Randomized bench for sram_vec_reader: an SRAM model answers reads and a job-level
// model (expected word list, accept/pop counts) predicts every observable output.
module tb_sram_vec_reader;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy;
    logic          done;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_byteenable;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic [DW-1:0] m_readdata;
    logic          m_waitrequest;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    logic [15:0]   salt;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clock = ~clock;

    // SRAM contents: a salted function of the address, so stale or repeated words show up.
    assign m_readdata = m_address[15:0] ^ {m_address[19:16], 12'h000} ^ salt;

    function automatic logic [15:0] sram_word(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h000} ^ salt;
    endfunction

    sram_vec_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BE_WIDTH  (BW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
        m_waitrequest = 1'b0; out_ready = 1'b1; salt = 16'h1234;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (m_read !== 1'b0)    begin n_err++; $display("FAIL reset_m_read got=%b exp=0", m_read); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== '0)    begin n_err++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_cmp++; if (m_address !== '0)   begin n_err++; $display("FAIL reset_m_address got=%h exp=0", m_address); end
        n_cmp++; if (m_write !== 1'b0 || m_writedata !== '0 || m_byteenable !== 2'b11)
            begin n_err++; $display("FAIL reset_write_side got=%b/%h/%b exp=0/0000/11", m_write, m_writedata, m_byteenable); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // wr_mode: 0 none, 1 random, 2 three-cycle stall on 2nd word.
    // rdy_mode: 0 always ready, 1 random, 2 not ready for the first 20 cycles.
    task automatic run_job(input logic [AW-1:0] base, input int n, input int wr_mode, input int rdy_mode);
        logic [15:0] exp_q[$];
        int    acc = 0;
        int    pops = 0;
        int    cyc = 0;
        int    stall = 0;
        bit    finished = 0;
        bit    exp_mread, exp_valid, exp_done, wr, rdy;
        logic [AW-1:0] exp_addr;

        salt = 16'($urandom);
        for (int i = 0; i < n; i++) exp_q.push_back(sram_word(base + AW'(i)));

        @(negedge clock);
        start = 1'b1; base_addr = base; word_count = (AW + 1)'(n);
        m_waitrequest = 1'b0;
        out_ready = (rdy_mode != 2);
        while (!finished && cyc < 3000) begin
            @(negedge clock);
            start = 1'b0;
            cyc++;
            case (wr_mode)
                1:       wr = ($urandom_range(0, 3) == 0);
                2:       wr = (acc == 1) && (stall < 3);
                default: wr = 1'b0;
            endcase
            if (wr_mode == 2 && wr) stall++;
            case (rdy_mode)
                1:       rdy = $urandom_range(0, 1) != 0;
                2:       rdy = (cyc > 20);
                default: rdy = 1'b1;
            endcase
            m_waitrequest = wr;
            out_ready = rdy;
            #1;
            exp_mread = (acc < n) && ((acc - pops) < DEPTH);
            exp_valid = (acc - pops) > 0;
            exp_done  = (pops == n);
            exp_addr  = base + AW'(acc);
            n_cmp++; if (m_read !== exp_mread)
                begin n_err++; $display("FAIL m_read cyc=%0d got=%b exp=%b", cyc, m_read, exp_mread); end
            if (exp_mread) begin
                n_cmp++; if (m_address !== exp_addr)
                    begin n_err++; $display("FAIL m_address cyc=%0d got=%h exp=%h", cyc, m_address, exp_addr); end
            end
            n_cmp++; if (out_valid !== exp_valid)
                begin n_err++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
            if (exp_valid) begin
                n_cmp++; if (out_data !== exp_q[pops])
                    begin n_err++; $display("FAIL out_data word=%0d got=%h exp=%h", pops, out_data, exp_q[pops]); end
            end
            n_cmp++; if (done !== exp_done)
                begin n_err++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done); end
            n_cmp++; if (busy !== 1'b1)
                begin n_err++; $display("FAIL busy_in_job cyc=%0d got=%b exp=1", cyc, busy); end
            if (rdy_mode == 2 && cyc == 20) begin
                n_cmp++; if (acc != ((n < DEPTH) ? n : DEPTH))
                    begin n_err++; $display("FAIL stalled_accepts got=%0d exp=%0d", acc, (n < DEPTH) ? n : DEPTH); end
            end
            if (exp_done) finished = 1;
            if (exp_mread && !wr) acc++;
            if (exp_valid && rdy) pops++;
        end
        if (!finished) begin
            n_cmp++; n_err++;
            $display("FAIL job_timeout got=%0d popped exp=%0d", pops, n);
        end
        @(negedge clock);
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0)
            begin n_err++; $display("FAIL after_done got=busy%b/done%b exp=busy0/done0", busy, done); end
    endtask

    task automatic test_basic();
        run_job(20'h00010, 4, 0, 0);
    endtask

    task automatic test_waitrequest();
        run_job(20'h00200, 5, 2, 0);
    endtask

    task automatic test_fifo_full();
        run_job(20'h03000, 12, 0, 2);
    endtask

    task automatic test_wrap();
        run_job(20'hFFFFE, 4, 0, 0);
    endtask

    task automatic test_zero_count();
        bit saw_read = 0;
        @(negedge clock);
        start = 1'b1; word_count = '0; base_addr = 20'h00ABC;
        #1;
        saw_read = m_read;
        @(negedge clock);
        start = 1'b0;
        #1;
        saw_read |= m_read;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done got=%b exp=1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy got=%b exp=0", busy); end
        @(negedge clock);
        #1;
        saw_read |= m_read;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_width got=%b exp=0", done); end
        n_cmp++; if (saw_read !== 1'b0) begin n_err++; $display("FAIL zero_m_read got=%b exp=0", saw_read); end
    endtask

    task automatic test_abort();
        bit saw_done = 0;
        salt = 16'($urandom);
        @(negedge clock);
        start = 1'b1; base_addr = 20'h04440; word_count = 21'd10;
        out_ready = 1'b0; m_waitrequest = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        n_cmp++; if (out_valid !== 1'b1 || m_read !== 1'b1)
            begin n_err++; $display("FAIL pre_abort got=valid%b/read%b exp=valid1/read1", out_valid, m_read); end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_cmp++; if (m_read !== 1'b0)    begin n_err++; $display("FAIL abort_m_read got=%b exp=0", m_read); end
        out_ready = 1'b1;
        repeat (6) begin
            saw_done |= done;
            @(negedge clock);
            #1;
        end
        n_cmp++; if (saw_done !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL abort_quiet got=done%b/busy%b exp=done0/busy0", saw_done, busy); end
        run_job(20'h05550, 6, 0, 0);
    endtask

    task automatic test_reset_mid_job();
        bit saw_done = 0;
        @(negedge clock);
        start = 1'b1; base_addr = 20'h06000; word_count = 21'd10; out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || m_read !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || m_address !== '0)
            begin n_err++; $display("FAIL async_reset got=busy%b/read%b/valid%b/data%h/addr%h exp=all zero",
                busy, m_read, out_valid, out_data, m_address); end
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (15) begin
            @(negedge clock);
            #1;
            saw_done |= done;
        end
        n_cmp++; if (saw_done !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL reset_lost_job got=done%b/busy%b exp=done0/busy0", saw_done, busy); end
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++)
            run_job(AW'($urandom), $urandom_range(1, 20), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waitrequest();
        test_fifo_full();
        test_wrap();
        test_zero_count();
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_vec_reader.md
SRAM_VEC_READER -- requirements
Module: sram_vec_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, meaning the SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the SRAM word width.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, meaning the byte-enable width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning the read-buffer depth (power of two, at least 2).
REQ-005 SHALL have port clock, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle job request.
REQ-008 SHALL have port abort, input, 1, cancels the job and flushes the buffer.
REQ-009 SHALL have port base_addr, input, ADDR_WIDTH, first word address; sampled on accepted start.
REQ-010 SHALL have port word_count, input, ADDR_WIDTH+1, words to read; sampled on accepted start.
REQ-011 SHALL have port busy, output, 1, high when state is not IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have ports m_address (output, ADDR_WIDTH), m_byteenable (output, BE_WIDTH), m_read (output, 1), m_write (output, 1), m_writedata (output, DATA_WIDTH), m_readdata (input, DATA_WIDTH) and m_waitrequest (input, 1), forming an Avalon-MM master into one port of the SRAM arbiter.
REQ-014 SHALL have ports out_data (output, DATA_WIDTH), out_valid (output, 1) and out_ready (input, 1), a valid/ready word stream to the test runner.

Function
REQ-015 SHALL drive m_write=0, m_writedata=0 and m_byteenable all-ones permanently.
REQ-016 SHALL implement states IDLE, READ and DRAIN.
REQ-017 In IDLE, start with word_count!=0 SHALL load the address and remaining registers and go to READ next cycle.
REQ-018 In IDLE, start with word_count==0 SHALL pulse done the next cycle and stay in IDLE.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL drive m_read = (state==READ) and (fifo_count<FIFO_DEPTH), decoded from registers only, with no combinational path from out_ready or m_waitrequest.
REQ-021 A read SHALL be accepted on a rising edge where m_read=1 and m_waitrequest=0, and m_readdata SHALL be pushed into the FIFO on that same edge (zero-latency slave).
REQ-022 SHALL hold m_address and m_read stable while m_waitrequest=1, except on abort.
REQ-023 On acceptance, m_address SHALL increment by 1, wrapping modulo 2^ADDR_WIDTH, and remaining SHALL decrement by 1.
REQ-024 An acceptance with remaining==1 SHALL move the block to DRAIN.
REQ-025 In DRAIN, once the FIFO is empty, the block SHALL pulse done for one cycle and return to IDLE in that same cycle.
REQ-026 SHALL set out_valid = (fifo_count!=0) and present the FIFO head on out_data, in order.
REQ-027 A pop SHALL occur when out_valid and out_ready are both high.
REQ-028 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-029 When the FIFO is full, m_read SHALL be 0; a pop in that cycle SHALL re-enable m_read on the next cycle only.
REQ-030 abort in any state SHALL, on the next edge, empty the FIFO, go to IDLE and suppress done; m_read SHALL drop at that edge. abort has priority over start and over any acceptance in the same cycle.

Reset
REQ-031 While reset_n=0, the block SHALL be in IDLE with the FIFO empty, m_address=0, remaining=0, and busy, done, m_read and out_valid all 0; out_data SHALL be 0.
REQ-032 Reset SHALL take effect immediately, independent of clock, including mid-job; after reset release, no done pulse SHALL occur for the lost job.

Verification
REQ-033 base_addr=0x00010, count=4, waitrequest=0, out_ready=1 -> m_address 0x10..0x13 on consecutive cycles, 4 words out in order, done one cycle after last pop.
REQ-034 waitrequest high 3 cycles on the 2nd word -> m_address held at base+1 with m_read high, no duplicate or lost word.
REQ-035 count=12, out_ready=0 -> exactly 8 accepts then m_read=0; raise out_ready -> the remaining 4 are read and 12 words are delivered in order.
REQ-036 count=0 -> done pulse one cycle after start, m_read never asserted, busy stays 0.
REQ-037 abort after 3 of 10 words -> FIFO empty, out_valid=0, busy=0, no done; a new start then works normally.
REQ-038 base_addr=0xFFFFE, count=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
